// File: rtl/seq_det_ctrl.sv
// Word-level controller for a serial pattern detector.
// Scans each accepted word MSB-first, one bit per clock, and returns count + hit mask.
module seq_det_ctrl #(
  parameter int                   WORD_W  = 8,
  parameter int                   PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0]   PATTERN = 4'b1101,
  parameter int                   CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              overlap,
  input  logic              carry,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic [WORD_W-1:0] out_hit_mask
);

  localparam int IDX_W  = $clog2(WORD_W);
  localparam int FILL_W = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);
  localparam logic [IDX_W-1:0]  IDX_TOP  = IDX_W'(WORD_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_valid;
  logic [WORD_W-1:0]   r_word;
  logic                r_ovl;
  logic [IDX_W-1:0]    r_idx;
  logic [PAT_LEN-2:0]  r_hist;
  logic [FILL_W-1:0]   r_fill;
  logic [CNT_W-1:0]    r_count;
  logic [WORD_W-1:0]   r_mask;

  logic                w_bit;
  logic [PAT_LEN-1:0]  w_window;
  logic                w_match;
  logic                w_accept;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_bit    = r_word[r_idx];
  assign w_window = {r_hist, w_bit};
  assign w_match  = (r_state == S_SHIFT) &&
                    (w_window == PATTERN) &&
                    (r_fill >= FILL_MAX);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= (w_next == S_DONE);
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid) w_next = S_SHIFT;
      S_SHIFT: if (r_idx == '0) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready     = (r_state == S_IDLE);
    out_valid    = r_valid;
    out_count    = r_count;
    out_hit_mask = r_mask;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_word  <= '0;
      r_ovl   <= 1'b0;
      r_idx   <= '0;
      r_hist  <= '0;
      r_fill  <= '0;
      r_count <= '0;
      r_mask  <= '0;
    end else if (w_accept) begin
      r_word  <= in_data;
      r_ovl   <= overlap;
      r_idx   <= IDX_TOP;
      r_count <= '0;
      r_mask  <= '0;
      if (!carry) begin
        r_hist <= '0;
        r_fill <= '0;
      end
    end else if (r_state == S_SHIFT) begin
      r_idx <= r_idx - IDX_W'(1);
      if (w_match) begin
        r_mask[r_idx] <= 1'b1;
        if (r_count != '1)
          r_count <= r_count + CNT_W'(1);
      end
      // Non-overlap: a match consumes all its bits.
      if (w_match && !r_ovl) begin
        r_hist <= '0;
        r_fill <= '0;
      end else begin
        r_hist <= w_window[PAT_LEN-2:0];
        if (r_fill != FILL_MAX)
          r_fill <= r_fill + FILL_W'(1);
      end
    end
  end

endmodule
